// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision normaliser datapath.
// FP16_NORM_FAST_EN selects the single-cycle leading-zero path in fp16_normalizer.
package fp16_pkg;

    typedef enum logic [2:0] {
        ZERO      = 3'd0,
        SUBNORMAL = 3'd1,
        NORMAL    = 3'd2,
        INF       = 3'd3,
        NAN       = 3'd4
    } fp16_class_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_t;

    localparam int FP16_BIAS   = 15;
    localparam int FP16_EMIN   = -14;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;

    // Leading zeros of a 10-bit fraction; 10 when the fraction is zero.
    function automatic logic [3:0] fp16_lzc10(input logic [9:0] f);
        fp16_lzc10 = 4'd10;
        for (int i = 0; i < 10; i++) begin
            if (f[i]) fp16_lzc10 = 4'(9 - i);
        end
    endfunction

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 classifier.
// Maps exponent/fraction fields onto fp16_class_t.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [FP16_EXP_W-1:0]  exp,
    input  logic [FP16_FRAC_W-1:0] frac,
    output fp16_class_t            cls
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (exp == '0);
    assign exp_ones  = (exp == {FP16_EXP_W{1'b1}});
    assign frac_zero = (frac == '0);

    always_comb begin
        cls = NORMAL;
        unique case (1'b1)
            exp_zero &  frac_zero: cls = ZERO;
            exp_zero & ~frac_zero: cls = SUBNORMAL;
            exp_ones &  frac_zero: cls = INF;
            exp_ones & ~frac_zero: cls = NAN;
            default:               cls = NORMAL;
        endcase
    end

endmodule

// File: rtl/fp16_normalizer.sv
// Binary16 normaliser: sign, unbiased exponent and explicit-one mantissa.
// FP16_NORM_FAST_EN replaces the per-bit SHIFT loop with a leading-zero count.
module fp16_normalizer
    import fp16_pkg::*;
#(
    parameter int EXP_W = 7
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [15:0]             in_x,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_sign,
    output logic signed [EXP_W-1:0] out_exp,
    output logic [10:0]             out_mant,
    output logic [2:0]              out_class,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [FP16_EXP_W-1:0]  e;
    logic [FP16_FRAC_W-1:0] frac;
    fp16_class_t            cls;
    norm_state_t            state;

    assign e    = in_x[14:10];
    assign frac = in_x[9:0];

    fp16_classify u_classify (
        .exp  (e),
        .frac (frac),
        .cls  (cls)
    );

`ifdef FP16_NORM_FAST_EN
    logic [3:0]  lz;
    logic [3:0]  k;
    logic [10:0] sub_mant;
    logic signed [EXP_W-1:0] sub_exp;

    // k shifts bring the leading fraction bit into the implicit-one slot.
    assign lz       = fp16_lzc10(frac);
    assign k        = lz + 4'd1;
    assign sub_mant = {1'b0, frac} << k;
    assign sub_exp  = EXP_W'(FP16_EMIN) - EXP_W'(k);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_class <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_sign  <= in_x[15];
                        out_class <= cls;
                        case (cls)
                            NORMAL: begin
                                out_exp  <= EXP_W'({1'b0, e})
                                          - EXP_W'(FP16_BIAS);
                                out_mant <= {1'b1, frac};
                                state    <= DONE;
                            end
                            ZERO: begin
                                out_exp  <= '0;
                                out_mant <= '0;
                                state    <= DONE;
                            end
                            SUBNORMAL: begin
`ifdef FP16_NORM_FAST_EN
                                out_exp  <= sub_exp;
                                out_mant <= sub_mant;
                                state    <= DONE;
`else
                                out_exp  <= EXP_W'(FP16_EMIN);
                                out_mant <= {1'b0, frac};
                                state    <= SHIFT;
`endif
                            end
                            INF, NAN: begin
                                out_exp  <= EXP_W'(16);
                                out_mant <= {1'b0, frac};
                                state    <= DONE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
`ifndef FP16_NORM_FAST_EN
                SHIFT: begin
                    out_mant <= out_mant << 1;
                    out_exp  <= out_exp - EXP_W'(1);
                    // Pre-shift bit 9 lands in bit 10 on this edge.
                    if (out_mant[9]) state <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_normalizer.sv
// Directed self-checking bench for fp16_normalizer.
// Expected latencies follow FP16_NORM_FAST_EN when it is defined.
module tb_fp16_normalizer;

    localparam int EXP_W = 7;

`ifdef FP16_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic                    clock;
    logic                    reset_n;
    logic [15:0]             in_x;
    logic                    in_valid;
    logic                    in_ready;
    logic                    out_sign;
    logic signed [EXP_W-1:0] out_exp;
    logic [10:0]             out_mant;
    logic [2:0]              out_class;
    logic                    out_valid;
    logic                    out_ready;

    int n_checks;
    int n_fails;

    fp16_normalizer #(.EXP_W(EXP_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_x      (in_x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_class (out_class),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic signed [EXP_W-1:0] v);
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept one operand, measure latency, check fields, then retire.
    task automatic run(input string tag, input logic [15:0] x,
                       input int lat, input logic s, input int e,
                       input logic [10:0] m, input logic [2:0] c);
        int cyc;
        bit busy_ok;
        check({tag, ".idle"}, 32'(in_ready), 32'd1);
        in_x     = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && cyc < 20) begin
            if (in_ready) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(lat));
        check({tag, ".busy"}, 32'(busy_ok), 32'd1);
        check({tag, ".sign"}, 32'(out_sign), 32'(s));
        check({tag, ".exp"}, sx(out_exp), 32'(e));
        check({tag, ".mant"}, 32'(out_mant), 32'(m));
        check({tag, ".class"}, 32'(out_class), 32'(c));
        tick();
    endtask

    initial begin : main
        logic [31:0] snap;
        n_checks  = 0;
        n_fails   = 0;
        reset_n   = 1'b0;
        in_x      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.sign", 32'(out_sign), 32'd0);
        check("rst.exp", sx(out_exp), 32'd0);
        check("rst.mant", 32'(out_mant), 32'd0);
        check("rst.class", 32'(out_class), 32'd0);

        run("one", 16'h3C00, 1, 1'b0, 0, 11'h400, 3'd2);
        run("neg", 16'hC500, 1, 1'b1, 2, 11'h500, 3'd2);
        run("maxn", 16'h7BFF, 1, 1'b0, 15, 11'h7FF, 3'd2);
        run("minn", 16'h0400, 1, 1'b0, -14, 11'h400, 3'd2);
        run("sub1", 16'h0001, FAST ? 1 : 11, 1'b0, -24, 11'h400, 3'd1);
        run("sub200", 16'h8200, FAST ? 1 : 2, 1'b1, -15, 11'h400, 3'd1);
        run("sub155", 16'h0155, FAST ? 1 : 3, 1'b0, -16, 11'h554, 3'd1);
        run("nan", 16'h7E00, 1, 1'b0, 16, 11'h200, 3'd4);
        run("ninf", 16'hFC00, 1, 1'b1, 16, 11'h000, 3'd3);
        run("zero", 16'h0000, 1, 1'b0, 0, 11'h000, 3'd0);
        run("nzero", 16'h8000, 1, 1'b1, 0, 11'h000, 3'd0);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        in_x      = 16'h3C00;
        in_valid  = 1'b1;
        tick();
        in_x = 16'h0001;
        check("bp.valid0", 32'(out_valid), 32'd1);
        snap = {17'd0, out_sign, out_exp, out_mant, out_class};
        check("bp.snap", snap, {17'd0, 1'b0, 7'd0, 11'h400, 3'd2});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.valid", 32'(out_valid), 32'd1);
            check("bp.ready", 32'(in_ready), 32'd0);
            check("bp.hold", {17'd0, out_sign, out_exp, out_mant, out_class},
                  snap);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp.retire", 32'(out_valid), 32'd0);
        run("bp.next", 16'hFC00, 1, 1'b1, 16, 11'h000, 3'd3);

        // Reset pulse while a subnormal is in flight.
        in_x     = 16'h0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("mrst.valid", 32'(out_valid), 32'd0);
        check("mrst.mant", 32'(out_mant), 32'd0);
        check("mrst.class", 32'(out_class), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("mrst.ready", 32'(in_ready), 32'd1);
        check("mrst.novalid", 32'(out_valid), 32'd0);
        run("mrst.one", 16'h3C00, 1, 1'b0, 0, 11'h400, 3'd2);
        tick();
        check("mrst.quiet", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
